// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: registered immediate / load-data extension stage.
// Each accepted request is extended once at acceptance and stored in a
// two-entry FIFO. Entry 0 doubles as the output register, so out_data and
// out_err come straight from flops. Entry 1 is the skid slot that absorbs
// one request while the consumer stalls.
module ext_pipe_unit #(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic [OFF_W-1:0] in_off,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_err
);

    localparam logic [2:0] OP_ZERO16 = 3'd0;
    localparam logic [2:0] OP_SIGN16 = 3'd1;
    localparam logic [2:0] OP_LUI16  = 3'd2;
    localparam logic [2:0] OP_LB     = 3'd3;
    localparam logic [2:0] OP_LBU    = 3'd4;
    localparam logic [2:0] OP_LH     = 3'd5;
    localparam logic [2:0] OP_LHU    = 3'd6;
    localparam logic [2:0] OP_LW     = 3'd7;

    // Returns {err, data} for one request. Loads first shift the addressed
    // byte lane down to bit 0 and then overwrite the upper bits with the
    // extension bit. Misaligned halves and words yield zero data with err set.
    function automatic logic [XLEN:0] ext_calc(
        input logic [2:0]       op,
        input logic [XLEN-1:0]  d,
        input logic [OFF_W-1:0] off
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        logic            err;
        sh  = d >> {off, 3'b000};
        res = {XLEN{1'b0}};
        err = 1'b0;
        case (op)
            OP_ZERO16: res = {{(XLEN-16){1'b0}}, d[15:0]};
            OP_SIGN16: res = {{(XLEN-16){d[15]}}, d[15:0]};
            OP_LUI16:  res = {d[15:0], {(XLEN-16){1'b0}}};
            OP_LB, OP_LBU: begin
                res = sh;
                for (int i = 8; i < XLEN; i++) begin
                    res[i] = (op == OP_LB) ? sh[7] : 1'b0;
                end
            end
            OP_LH, OP_LHU: begin
                if (off[0]) begin
                    err = 1'b1;
                end else begin
                    res = sh;
                    for (int i = 16; i < XLEN; i++) begin
                        res[i] = (op == OP_LH) ? sh[15] : 1'b0;
                    end
                end
            end
            OP_LW: begin
                if (off[1:0] != 2'd0) begin
                    err = 1'b1;
                end else begin
                    res = sh;
                    for (int i = 32; i < XLEN; i++) begin
                        res[i] = sh[31];
                    end
                end
            end
            default: begin
                res = {XLEN{1'b0}};
                err = 1'b0;
            end
        endcase
        return {err, res};
    endfunction

    logic [1:0]      count_r;
    logic [1:0]      count_nxt_s;
    logic [XLEN-1:0] ent1_data_r;
    logic            ent1_err_r;
    logic            push_s;
    logic            pop_s;
    logic [XLEN:0]   calc_s;

    // The ready decision uses only the registered count, so out_ready has no path into in_ready.
    assign in_ready = !rst && (count_r != 2'd2);

    // Handshake decode, extension of the incoming request, and next occupancy.
    always_comb begin
        push_s      = in_valid && in_ready;
        pop_s       = out_valid && out_ready;
        calc_s      = ext_calc(in_op, in_data, in_off);
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage: entry 0 is the output register and entry 1 is the skid slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= {XLEN{1'b0}};
            out_err     <= 1'b0;
            ent1_data_r <= {XLEN{1'b0}};
            ent1_err_r  <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            out_valid <= (count_nxt_s != 2'd0);
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        {out_err, out_data} <= calc_s;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        {out_err, out_data} <= calc_s;
                    end else if (push_s) begin
                        {ent1_err_r, ent1_data_r} <= calc_s;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        out_data <= ent1_data_r;
                        out_err  <= ent1_err_r;
                    end
                end
                default: begin
                    out_data <= out_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed bench for ext_pipe_unit. It drives a 32-bit and a 64-bit instance
// from one vector table, then runs the stall/ordering and reset-flush sequences.
module tb_ext_pipe_unit;

    logic        clk;
    logic        rst;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_err;
    logic [31:0] n_in_data, n_out_data;
    logic [1:0]  n_in_off;
    logic [2:0]  n_in_op;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err;
    logic [63:0] w_in_data, w_out_data;
    logic [2:0]  w_in_off;
    logic [2:0]  w_in_op;

    int checks   = 0;
    int failures = 0;

    ext_pipe_unit #(.XLEN(32)) dut_n (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .in_off(n_in_off), .in_op(n_in_op),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .out_err(n_out_err)
    );

    ext_pipe_unit #(.XLEN(64)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_off(w_in_off), .in_op(w_in_op),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_err(w_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wide;
        logic [2:0]  op;
        logic [2:0]  off;
        logic [63:0] d;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // immediates, applied back-to-back
        vecs[0]  = '{1'b0, 3'd1, 3'd0, 64'h0000fe34, 64'hfffffe34, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 3'd0, 64'h0000fe34, 64'h0000fe34, 1'b0};
        vecs[2]  = '{1'b0, 3'd2, 3'd0, 64'h0000fe34, 64'hfe340000, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 3'd3, 64'habcd7fff, 64'h00007fff, 1'b0};
        // bytes
        vecs[4]  = '{1'b0, 3'd3, 3'd3, 64'h807f1234, 64'hffffff80, 1'b0};
        vecs[5]  = '{1'b0, 3'd4, 3'd3, 64'h807f1234, 64'h00000080, 1'b0};
        vecs[6]  = '{1'b0, 3'd3, 3'd2, 64'h807f1234, 64'h0000007f, 1'b0};
        vecs[7]  = '{1'b0, 3'd4, 3'd0, 64'h807f1234, 64'h00000034, 1'b0};
        vecs[8]  = '{1'b0, 3'd3, 3'd1, 64'h807f1234, 64'h00000012, 1'b0};
        // halves and words
        vecs[9]  = '{1'b0, 3'd5, 3'd2, 64'h80011234, 64'hffff8001, 1'b0};
        vecs[10] = '{1'b0, 3'd6, 3'd2, 64'h80011234, 64'h00008001, 1'b0};
        vecs[11] = '{1'b0, 3'd5, 3'd1, 64'h80011234, 64'h00000000, 1'b1};
        vecs[12] = '{1'b0, 3'd7, 3'd2, 64'h80011234, 64'h00000000, 1'b1};
        vecs[13] = '{1'b0, 3'd7, 3'd0, 64'h80011234, 64'h80011234, 1'b0};
        vecs[14] = '{1'b0, 3'd6, 3'd3, 64'h80011234, 64'h00000000, 1'b1};
        // 64-bit instance
        vecs[15] = '{1'b1, 3'd7, 3'd4, 64'h80000000_00000001, 64'hffffffff_80000000, 1'b0};
        vecs[16] = '{1'b1, 3'd7, 3'd0, 64'h80000000_00000001, 64'h00000000_00000001, 1'b0};
        vecs[17] = '{1'b1, 3'd7, 3'd2, 64'h80000000_00000001, 64'h0, 1'b1};
        vecs[18] = '{1'b1, 3'd2, 3'd0, 64'h00000000_0000fe34, 64'hfe340000_00000000, 1'b0};

        rst = 1'b1;
        n_in_valid = 1'b0; n_in_data = 32'h0; n_in_off = 2'd0; n_in_op = 3'd0; n_out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = 64'h0; w_in_off = 3'd0; w_in_op = 3'd0; w_out_ready = 1'b1;

        // reset state
        #2;
        check("rst_in_ready", {63'd0, n_in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, n_out_valid}, 64'd0);
        check("rst_out_data", {32'd0, n_out_data}, 64'd0);
        check("rst_out_err", {63'd0, n_out_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, n_in_ready}, 64'd1);
        check("post_rst_w_in_ready", {63'd0, w_in_ready}, 64'd1);

        // table: one request per cycle, result due after the accepting edge
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            n_in_valid = !vecs[i].wide;
            w_in_valid = vecs[i].wide;
            n_in_data  = vecs[i].d[31:0];
            n_in_off   = vecs[i].off[1:0];
            n_in_op    = vecs[i].op;
            w_in_data  = vecs[i].d;
            w_in_off   = vecs[i].off;
            w_in_op    = vecs[i].op;
            @(posedge clk);
            #1;
            if (vecs[i].wide) begin
                check($sformatf("v%0d_valid", i), {63'd0, w_out_valid}, 64'd1);
                check($sformatf("v%0d_data", i), w_out_data, vecs[i].exp_data);
                check($sformatf("v%0d_err", i), {63'd0, w_out_err}, {63'd0, vecs[i].exp_err});
            end else begin
                check($sformatf("v%0d_valid", i), {63'd0, n_out_valid}, 64'd1);
                check($sformatf("v%0d_data", i), {32'd0, n_out_data}, vecs[i].exp_data);
                check($sformatf("v%0d_err", i), {63'd0, n_out_err}, {63'd0, vecs[i].exp_err});
            end
        end
        @(negedge clk);
        n_in_valid = 1'b0;
        w_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", {63'd0, n_out_valid}, 64'd0);

        // back-pressure: three offers while the consumer stalls
        @(negedge clk);
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_op = 3'd0; n_in_off = 2'd0; n_in_data = 32'h00001111;
        check("bp_ready_a", {63'd0, n_in_ready}, 64'd1);
        @(negedge clk);
        n_in_op = 3'd1; n_in_data = 32'h00008002;
        check("bp_ready_b", {63'd0, n_in_ready}, 64'd1);
        check("bp_head_a", {32'd0, n_out_data}, 64'h00001111);
        @(negedge clk);
        n_in_op = 3'd2; n_in_data = 32'h00000003;
        check("bp_full", {63'd0, n_in_ready}, 64'd0);
        @(negedge clk);
        check("bp_still_full", {63'd0, n_in_ready}, 64'd0);
        check("bp_hold_data", {32'd0, n_out_data}, 64'h00001111);
        check("bp_hold_valid", {63'd0, n_out_valid}, 64'd1);
        n_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_b", {32'd0, n_out_data}, 64'hffff8002);
        check("bp_ready_after", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("bp_out_c", {32'd0, n_out_data}, 64'h00030000);
        check("bp_out_c_valid", {63'd0, n_out_valid}, 64'd1);
        @(negedge clk);
        n_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_empty", {63'd0, n_out_valid}, 64'd0);

        // reset while full: stored entries must be discarded
        @(negedge clk);
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_op = 3'd4; n_in_off = 2'd1; n_in_data = 32'h0000aa00;
        @(negedge clk);
        n_in_data = 32'h0000bb00;
        @(negedge clk);
        n_in_valid = 1'b0;
        check("rf_full", {63'd0, n_in_ready}, 64'd0);
        check("rf_valid", {63'd0, n_out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rf_valid_async", {63'd0, n_out_valid}, 64'd0);
        check("rf_ready_async", {63'd0, n_in_ready}, 64'd0);
        check("rf_data_async", {32'd0, n_out_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_out_ready = 1'b1;
        #1;
        check("rf_ready_release", {63'd0, n_in_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rf_no_ghost%0d", k), {63'd0, n_out_valid}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
